// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, 2**ADDR_WIDTH x DATA_WIDTH words.
// Wrap-bit pointers for full/empty, registered read data.
module sync_fifo #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Wr_enable,
  input  logic                  Read_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0]   write_ptr, wr_ptr_d;
  logic [ADDR_WIDTH:0]   read_ptr, rd_ptr_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  logic wr_acc, rd_acc;

  // Status flags straight from the registered pointers
  always_comb begin
    empty = (write_ptr == read_ptr);
    full  = (write_ptr[ADDR_WIDTH] != read_ptr[ADDR_WIDTH]) &&
            (write_ptr[ADDR_WIDTH-1:0] == read_ptr[ADDR_WIDTH-1:0]);
  end

  // Accept decisions and next-state pointers/data
  always_comb begin
    wr_acc     = Wr_enable && !full;
    rd_acc     = Read_enable && !empty;
    wr_ptr_d   = write_ptr;
    rd_ptr_d   = read_ptr;
    data_out_d = data_out_q;
    if (wr_acc) begin
      wr_ptr_d = write_ptr + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d   = read_ptr + 1'b1;
      data_out_d = mem[read_ptr[ADDR_WIDTH-1:0]];
    end
  end

  // Pointer and read-data registers, reset first
  always_ff @(posedge clk) begin
    if (reset) begin
      write_ptr  <= '0;
      read_ptr   <= '0;
      data_out_q <= '0;
    end else begin
      write_ptr  <= wr_ptr_d;
      read_ptr   <= rd_ptr_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage array; contents survive reset
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem[write_ptr[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: queue-model scoreboard plus directed literals
// for sync_fifo at default parameters (4 x 32).
module tb_sync_fifo;

  localparam int AW    = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          reset;
  logic          Wr_enable;
  logic          Read_enable;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;

  sync_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .Wr_enable   (Wr_enable),
    .Read_enable (Read_enable),
    .data_in     (data_in),
    .data_out    (data_out),
    .full        (full),
    .empty       (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout;
  int            m_wcnt;
  bit            armed = 0;
  bit            done  = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Reference model: occupancy queue, judged on pre-edge state
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        mq.delete();
        m_dout = '0;
        m_wcnt = 0;
        armed  = 1;
      end else begin
        bit f, e;
        f = (mq.size() == DEPTH);
        e = (mq.size() == 0);
        if (Read_enable && !e) m_dout = mq.pop_front();
        if (Wr_enable && !f) begin
          mq.push_back(data_in);
          m_wcnt = (m_wcnt + 1) % (2 * DEPTH);
        end
      end
    end
  end

  // Per-cycle compare on the falling edge
  initial begin
    logic [AW:0] prev_wp;
    bit          prev_acc;
    prev_acc = 0;
    prev_wp  = '0;
    forever begin
      @(negedge clk);
      if (armed && !done) begin
        chk("data_out", 64'(data_out), 64'(m_dout));
        chk("full", 64'(full), 64'(mq.size() == DEPTH));
        chk("empty", 64'(empty), 64'(mq.size() == 0));
        chk("not_both", 64'(full && empty), 64'(0));
        chk("write_ptr", 64'(dut.write_ptr), 64'(m_wcnt));
        if (prev_acc && prev_wp[AW-1:0] != AW'(DEPTH - 1))
          chk("wp_incr", 64'(dut.write_ptr), 64'(prev_wp + 1'b1));
        prev_wp  = dut.write_ptr;
        prev_acc = Wr_enable && !full && !reset;
      end
    end
  end

  task automatic step(bit we, bit re, logic [DW-1:0] d, bit rst);
    Wr_enable   = we;
    Read_enable = re;
    data_in     = d;
    reset       = rst;
    @(posedge clk);
    #1;
    Wr_enable   = 1'b0;
    Read_enable = 1'b0;
    reset       = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    Wr_enable   = 1'b0;
    Read_enable = 1'b0;
    data_in     = '0;
    step(0, 0, 0, 1);
    // prior contents, then reset mid-stream
    step(1, 0, 32'h11, 0);
    step(1, 0, 32'h22, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_dout", 64'(data_out), 64'(0));
    chk("rst_wp", 64'(dut.write_ptr), 64'(0));

    // fill
    step(1, 0, 32'hA0, 0);
    chk("fill_empty", 64'(empty), 64'(0));
    step(1, 0, 32'hA1, 0);
    step(1, 0, 32'hA2, 0);
    step(1, 0, 32'hA3, 0);
    chk("fill_full", 64'(full), 64'(1));
    chk("fill_wp", 64'(dut.write_ptr), 64'(3'b100));

    // overflow
    step(1, 0, 32'hFF, 0);
    chk("ovf_full", 64'(full), 64'(1));
    chk("ovf_wp", 64'(dut.write_ptr), 64'(3'b100));

    // drain + underflow
    step(0, 1, 0, 0);
    chk("drain0", 64'(data_out), 64'hA0);
    step(0, 1, 0, 0);
    chk("drain1", 64'(data_out), 64'hA1);
    step(0, 1, 0, 0);
    chk("drain2", 64'(data_out), 64'hA2);
    step(0, 1, 0, 0);
    chk("drain3", 64'(data_out), 64'hA3);
    chk("drain_empty", 64'(empty), 64'(1));
    step(0, 1, 0, 0);
    chk("udf_dout", 64'(data_out), 64'hA3);

    // simultaneous with 2 words held
    step(1, 0, 32'hB0, 0);
    step(1, 0, 32'hB1, 0);
    step(1, 1, 32'hC0, 0);
    chk("sim0", 64'(data_out), 64'hB0);
    step(1, 1, 32'hC1, 0);
    chk("sim1", 64'(data_out), 64'hB1);
    step(1, 1, 32'hC2, 0);
    chk("sim2", 64'(data_out), 64'hC0);
    chk("sim_occ", 64'({full, empty}), 64'(0));

    // full with both enables: read only
    step(1, 0, 32'hD0, 0);
    step(1, 0, 32'hD1, 0);
    chk("full2", 64'(full), 64'(1));
    step(1, 1, 32'hEE, 0);
    chk("fb_dout", 64'(data_out), 64'hC1);
    chk("fb_full", 64'(full), 64'(0));
    step(0, 1, 0, 0);
    chk("fb_r0", 64'(data_out), 64'hC2);
    step(0, 1, 0, 0);
    chk("fb_r1", 64'(data_out), 64'hD0);
    step(0, 1, 0, 0);
    chk("fb_r2", 64'(data_out), 64'hD1);
    chk("fb_empty", 64'(empty), 64'(1));

    // empty with both enables: write only
    step(1, 1, 32'h77, 0);
    chk("eb_empty", 64'(empty), 64'(0));
    chk("eb_dout", 64'(data_out), 64'hD1);
    step(0, 1, 0, 0);
    chk("eb_r", 64'(data_out), 64'h77);

    // random with occasional reset
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom, $urandom_range(0, 49) == 0);
    end

    step(0, 0, 0, 0);
    done = 1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
